dram_portb_arbiter: RTL and testbench
=====================================

Name: dram_portb_arbiter

Overview:
- Sequences and shares the b-port of the data RAM (sync read, 1-cycle latency, 4-bit byte write enable) between two requesters: m0 = debug module, m1 = bulk loader/DMA.
- Single-word transactions, fully pipelined: one issue per cycle.
- Round-robin arbitration with an optional lock for atomic read-modify-write sequences.
- Responses are routed back to the issuing requester.

Parameters:
- ADDR_W, 32, byte address width.
- VALID_HI, 18, lowest address bit that must be zero for an access to be in-range (matches RAM window addr[31:18]==0).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- m0_req  in  1  request valid; held with its fields stable until m0_gnt.
- m0_we  in  4  byte write enables; 4'b0000 = read.
- m0_addr  in  32  byte address (bits [1:0] ignored).
- m0_wdata  in  32  write data.
- m0_lock  in  1  keep grant after this request while m0_req stays high.
- m0_gnt  out  1  combinational: request accepted this cycle.
- m0_rvalid  out  1  response pulse.
- m0_rdata  out  32  RAM word (pre-write content for writes).
- m0_err  out  1  out-of-range flag, valid with rvalid.
- m1_req, m1_we, m1_addr, m1_wdata, m1_lock, m1_gnt, m1_rvalid, m1_rdata, m1_err: same as m0.
- ram_addrb  out  32  to RAM addrb.
- ram_dinb  out  32  to RAM dinb.
- ram_web  out  4  to RAM web.
- ram_doutb  in  32  from RAM doutb.

Behaviour:
- Reset (async, rst=1):
  - ram_web=0, ram_addrb=0, ram_dinb=0.
  - All gnt, rvalid, err = 0; rdata = 0.
  - last=1, so m0 wins first; lock_owner cleared.
  - Pipeline valid bits cleared: in-flight responses are dropped, none issued after reset deasserts.
- Arbitration, cycle T, combinational:
  - Lock active: only the lock owner may be granted, and only if its req=1.
  - Otherwise, if exactly one req is high, that master is granted.
  - If both are high, the master != last is granted.
  - gnt is never asserted without req; at most one gnt per cycle.
- Edge at end of T (grant given):
  - last <= granted id.
  - Lock is set to the granted id if its lock=1; lock clears on the first cycle the owner's req=0 (no grant to the other master that cycle).
- Issue stage, registered:
  - In T+1: ram_addrb = addr, ram_dinb = wdata.
  - ram_web = we if addr[ADDR_W-1:VALID_HI]==0, else 4'b0 (write suppressed).
  - With no grant in T: ram_web=0 in T+1; ram_addrb/ram_dinb hold their previous values.
  - Stage carries valid, id and err bits.
- Response stage:
  - In T+2: m{id}_rvalid=1 for exactly one cycle.
  - m{id}_rdata = ram_doutb, or 0 when err; m{id}_err = err.
  - The other master's rvalid=0. rdata holds its value when rvalid=0.
- Latency: grant to rvalid = 2 cycles, for reads and writes alike. Throughput is 1 per cycle; back-to-back grants produce back-to-back responses in grant order.
- Read-after-write, same address, consecutive grants: the read returns the new data (RAM write commits at end of T+1, read samples at end of T+2).
- No response backpressure; requesters must accept rvalid.

Test Plan:
- Reset, then m0 write addr=0x10 we=4'hF data=0xDEADBEEF; m0 read 0x10.
  - Grants in consecutive cycles.
  - ram_web=F one cycle after the first grant.
  - Read rvalid two cycles after its grant with rdata=0xDEADBEEF, err=0.
- Byte write: m1 we=4'b0100 data=0x00AA0000 to 0x10, then read.
  - rdata = 0xDEAABEEF.
  - The write response rdata = 0xDEADBEEF (pre-write).
- m0_req and m1_req held high for 6 cycles, both reading.
  - Grants alternate m0, m1, m0, m1, m0, m1.
  - Responses alternate with 2-cycle lag; no cycle with both gnt high.
- m1 with lock=1 does read 0x20, then write 0x20, while m0_req is held high.
  - m1 gets two consecutive grants; m0 waits.
  - m1_req drops: no grant that cycle, m0 granted the next cycle.
- m0 write to 0x0004_0000.
  - ram_web=0 in the issue cycle; m0_err=1 with m0_rvalid; rdata=0; RAM contents unchanged.
- rst asserted in the cycle after an m0 grant (read in flight).
  - All outputs 0 immediately.
  - No m0_rvalid in the following 3 cycles after rst deasserts with no requests.

Source files
------------

// File: rtl/dram_portb_arbiter_if.sv
// Requester-side bus of the data RAM b-port arbiter.
// One instance per requester (debug module, bulk loader/DMA).
//   req    : request valid, fields held stable until gnt
//   we     : byte write enables, 4'b0000 = read
//   addr   : byte address (bits [1:0] ignored by the RAM)
//   wdata  : write data
//   lock   : keep ownership of the port after this request while req stays high
//   gnt    : combinational accept, this cycle
//   rvalid : one-cycle response pulse, two cycles after gnt
//   rdata  : RAM word (pre-write content for writes), held while rvalid=0
//   err    : out-of-range flag, valid with rvalid
// Modport master is the requester view, slave is the arbiter view.
interface dram_portb_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic [3:0]        we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              lock;
  logic              gnt;
  logic              rvalid;
  logic [31:0]       rdata;
  logic              err;

  modport master (
    output req, we, addr, wdata, lock,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata, lock,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/dram_portb_arbiter.sv
// Shares the b-port of the data RAM (sync read, 1-cycle latency, byte write
// enables, read-first) between two single-word requesters: m0 = debug module,
// m1 = bulk loader/DMA. Round-robin arbitration with an optional lock for
// atomic read-modify-write, one issue per cycle, responses routed back to the
// issuing requester two cycles after the grant.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   m0, m1              : requester buses (dram_portb_arbiter_if.slave)
//   ram_addrb/dinb/web  : registered RAM b-port command
//   ram_doutb           : RAM read data, valid the cycle after the command
module dram_portb_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int VALID_HI = 18
) (
  input  logic              clk,
  input  logic              rst,
  dram_portb_arbiter_if.slave m0,
  dram_portb_arbiter_if.slave m1,
  output logic [ADDR_W-1:0] ram_addrb,
  output logic [31:0]       ram_dinb,
  output logic [3:0]        ram_web,
  input  logic [31:0]       ram_doutb
);

  typedef enum logic [1:0] {
    LK_NONE = 2'd0,
    LK_M0   = 2'd1,
    LK_M1   = 2'd2
  } lk_state_t;

  lk_state_t         lk_state;
  lk_state_t         lk_next;
  logic              lock_active;
  logic              lock_owner;
  logic              last;

  logic              gnt0_p0;
  logic              gnt1_p0;
  logic              any_gnt_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [31:0]       wdata_p0;
  logic [3:0]        we_p0;
  logic              err_p0;

  logic              vld_p1;
  logic              id_p1;
  logic              err_p1;

  logic              vld_p2;
  logic              id_p2;
  logic              err_p2;
  logic [31:0]       resp_p2;
  logic              rvalid0;
  logic              rvalid1;
  logic [31:0]       hold0;
  logic [31:0]       hold1;

  // Anything above the RAM window is an error: writes are suppressed and
  // the response data forced to zero.
  function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
    return |a[ADDR_W-1:VALID_HI];
  endfunction

  // ---- p0: arbitration (combinational) ----
  always_comb begin
    gnt0_p0 = 1'b0;
    gnt1_p0 = 1'b0;
    if (rst) begin
      gnt0_p0 = 1'b0;
      gnt1_p0 = 1'b0;
    end else if (lock_active) begin
      // Only the owner may proceed; an owner with req=0 gets nothing and
      // the other master is still held off for that cycle.
      if (lock_owner) gnt1_p0 = m1.req;
      else            gnt0_p0 = m0.req;
    end else if (m0.req && m1.req) begin
      // last=1 means m1 went last, so m0 wins.
      gnt0_p0 = last;
      gnt1_p0 = ~last;
    end else begin
      gnt0_p0 = m0.req;
      gnt1_p0 = m1.req;
    end
  end

  assign any_gnt_p0 = gnt0_p0 | gnt1_p0;
  assign addr_p0    = gnt1_p0 ? m1.addr  : m0.addr;
  assign wdata_p0   = gnt1_p0 ? m1.wdata : m0.wdata;
  assign we_p0      = gnt1_p0 ? m1.we    : m0.we;
  assign err_p0     = out_of_range(addr_p0);

  assign m0.gnt = gnt0_p0;
  assign m1.gnt = gnt1_p0;

  // Lock FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lk_state <= LK_NONE;
    else     lk_state <= lk_next;
  end

  // Lock FSM: next state. An owner that drops req, or is granted with
  // lock=0, releases the port.
  always_comb begin
    lk_next = lk_state;
    case (lk_state)
      LK_NONE: begin
        if (gnt0_p0 && m0.lock)      lk_next = LK_M0;
        else if (gnt1_p0 && m1.lock) lk_next = LK_M1;
      end
      LK_M0: if (!m0.req || !m0.lock) lk_next = LK_NONE;
      LK_M1: if (!m1.req || !m1.lock) lk_next = LK_NONE;
      default: lk_next = LK_NONE;
    endcase
  end

  // Lock FSM: outputs
  always_comb begin
    lock_active = (lk_state != LK_NONE);
    lock_owner  = (lk_state == LK_M1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             last <= 1'b1;
    else if (any_gnt_p0) last <= gnt1_p0;
  end

  // ---- p1: issue to RAM ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      id_p1     <= 1'b0;
      err_p1    <= 1'b0;
      ram_web   <= 4'b0;
      ram_addrb <= '0;
      ram_dinb  <= '0;
    end else begin
      vld_p1  <= any_gnt_p0;
      ram_web <= 4'b0;
      if (any_gnt_p0) begin
        ram_addrb <= addr_p0;
        ram_dinb  <= wdata_p0;
        ram_web   <= err_p0 ? 4'b0 : we_p0;
        id_p1     <= gnt1_p0;
        err_p1    <= err_p0;
      end
    end
  end

  // ---- p2: response, RAM data arrives this cycle ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      id_p2  <= 1'b0;
      err_p2 <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      id_p2  <= id_p1;
      err_p2 <= err_p1;
    end
  end

  assign rvalid0 = vld_p2 & ~id_p2;
  assign rvalid1 = vld_p2 & id_p2;
  assign resp_p2 = err_p2 ? 32'h0 : ram_doutb;

  // rdata is a live view of the RAM during rvalid and otherwise shows the
  // last delivered word, so it holds between responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold0 <= 32'h0;
      hold1 <= 32'h0;
    end else begin
      if (rvalid0) hold0 <= resp_p2;
      if (rvalid1) hold1 <= resp_p2;
    end
  end

  assign m0.rvalid = rvalid0;
  assign m0.err    = rvalid0 & err_p2;
  assign m0.rdata  = rvalid0 ? resp_p2 : hold0;
  assign m1.rvalid = rvalid1;
  assign m1.err    = rvalid1 & err_p2;
  assign m1.rdata  = rvalid1 ? resp_p2 : hold1;

endmodule

// File: tb/tb_dram_portb_arbiter.sv
// Bench for dram_portb_arbiter: behavioural read-first RAM on the b-port, a
// cycle table of requester inputs with expected grants, and a scoreboard of
// responses built from a shadow memory at grant time.
module tb_dram_portb_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dram_portb_arbiter_if #(.ADDR_W(32)) m0_if ();
  dram_portb_arbiter_if #(.ADDR_W(32)) m1_if ();

  logic [31:0] ram_addrb;
  logic [31:0] ram_dinb;
  logic [3:0]  ram_web;
  logic [31:0] ram_doutb;

  dram_portb_arbiter #(.ADDR_W(32), .VALID_HI(18)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0        (m0_if),
    .m1        (m1_if),
    .ram_addrb (ram_addrb),
    .ram_dinb  (ram_dinb),
    .ram_web   (ram_web),
    .ram_doutb (ram_doutb)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cycle       = 0;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [31:0] init_word(input int i);
    return 32'hA500_0000 | i;
  endfunction

  // RAM model: read-first, 256 words, reloaded while rst is high.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else begin
      ram_doutb <= mem[ram_addrb[9:2]];
      for (int b = 0; b < 4; b++)
        if (ram_web[b]) mem[ram_addrb[9:2]][b*8 +: 8] <= ram_dinb[b*8 +: 8];
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cycle);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  typedef struct {
    logic        id;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        e;
  logic [31:0] shadow [0:255];
  logic [3:0]  exp_web = 4'b0;
  logic        mon_id;
  logic [31:0] mon_a;
  logic [31:0] mon_d;
  logic [3:0]  mon_w;
  logic        mon_er;
  logic [31:0] mon_rd;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        sbq.delete();
        exp_web = 4'b0;
        for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
      end else begin
        check("ram_web", {28'h0, ram_web}, {28'h0, exp_web});
        if (m0_if.rvalid && m1_if.rvalid)
          check("both_rvalid", 32'h1, 32'h0);
        if (m0_if.rvalid || m1_if.rvalid) begin
          if (sbq.size() == 0) begin
            check("unexpected_rvalid", {31'h0, m1_if.rvalid}, 32'hFFFF_FFFF);
          end else begin
            e      = sbq.pop_front();
            mon_id = m1_if.rvalid;
            mon_rd = mon_id ? m1_if.rdata : m0_if.rdata;
            mon_er = mon_id ? m1_if.err : m0_if.err;
            check("resp_id", {31'h0, mon_id}, {31'h0, e.id});
            check("resp_rdata", mon_rd, e.rdata);
            check("resp_err", {31'h0, mon_er}, {31'h0, e.err});
            check("resp_latency", cycle, e.cyc + 2);
          end
        end
        if (m0_if.gnt && m1_if.gnt) check("both_gnt", 32'h1, 32'h0);
        if (m0_if.gnt && !m0_if.req) check("gnt0_no_req", 32'h1, 32'h0);
        if (m1_if.gnt && !m1_if.req) check("gnt1_no_req", 32'h1, 32'h0);
        exp_web = 4'b0;
        if (m0_if.gnt || m1_if.gnt) begin
          mon_id = m1_if.gnt;
          mon_a  = mon_id ? m1_if.addr  : m0_if.addr;
          mon_d  = mon_id ? m1_if.wdata : m0_if.wdata;
          mon_w  = mon_id ? m1_if.we    : m0_if.we;
          mon_er = |mon_a[31:18];
          e.id    = mon_id;
          e.err   = mon_er;
          e.rdata = mon_er ? 32'h0 : shadow[mon_a[9:2]];
          e.cyc   = cycle;
          sbq.push_back(e);
          if (!mon_er) begin
            exp_web = mon_w;
            for (int b = 0; b < 4; b++)
              if (mon_w[b]) shadow[mon_a[9:2]][b*8 +: 8] = mon_d[b*8 +: 8];
          end
        end
      end
    end
  end

  // ---------------- stimulus table ----------------
  typedef struct {
    logic        r0;
    logic        l0;
    logic [3:0]  w0;
    logic [31:0] a0;
    logic [31:0] d0;
    logic        r1;
    logic        l1;
    logic [3:0]  w1;
    logic [31:0] a1;
    logic [31:0] d1;
    logic        g0;
    logic        g1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic r0, input logic l0, input logic [3:0] w0, input logic [31:0] a0, input logic [31:0] d0,
    input logic r1, input logic l1, input logic [3:0] w1, input logic [31:0] a1, input logic [31:0] d1,
    input logic g0, input logic g1);
    vec_t v;
    v.r0 = r0; v.l0 = l0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.l1 = l1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    m0_if.req = v.r0; m0_if.lock = v.l0; m0_if.we = v.w0; m0_if.addr = v.a0; m0_if.wdata = v.d0;
    m1_if.req = v.r1; m1_if.lock = v.l1; m1_if.we = v.w1; m1_if.addr = v.a1; m1_if.wdata = v.d1;
  endtask

  task automatic idle();
    drive(mk(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0));
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt0", {31'h0, m0_if.gnt}, 32'h0);
    check("rst_gnt1", {31'h0, m1_if.gnt}, 32'h0);
    check("rst_rvalid0", {31'h0, m0_if.rvalid}, 32'h0);
    check("rst_rvalid1", {31'h0, m1_if.rvalid}, 32'h0);
    check("rst_rdata0", m0_if.rdata, 32'h0);
    check("rst_rdata1", m1_if.rdata, 32'h0);
    check("rst_err0", {31'h0, m0_if.err}, 32'h0);
    check("rst_err1", {31'h0, m1_if.err}, 32'h0);
    check("rst_web", {28'h0, ram_web}, 32'h0);
    check("rst_addrb", ram_addrb, 32'h0);
    check("rst_dinb", ram_dinb, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // write then read, byte write then read
    tbl.push_back(mk(1, 0, 4'hF, 32'h10, 32'hDEADBEEF, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0));
    tbl.push_back(mk(1, 0, 4'h0, 32'h10, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0));
    tbl.push_back(mk(0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 4'b0100, 32'h10, 32'h00AA0000, 0, 1));
    tbl.push_back(mk(0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 4'h0, 32'h10, 32'h0, 0, 1));
    // both requesting: alternate
    for (int i = 0; i < 6; i++)
      tbl.push_back(mk(1, 0, 4'h0, 32'h10, 32'h0, 1, 0, 4'h0, 32'h20, 32'h0, (i % 2) == 0, (i % 2) == 1));
    // locked read-modify-write by m1 while m0 waits
    tbl.push_back(mk(0, 0, 4'h0, 32'h0, 32'h0, 1, 1, 4'h0, 32'h20, 32'h0, 0, 1));
    tbl.push_back(mk(1, 0, 4'h0, 32'h14, 32'h0, 1, 1, 4'hF, 32'h20, 32'h12345678, 0, 1));
    tbl.push_back(mk(1, 0, 4'h0, 32'h14, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0));
    tbl.push_back(mk(1, 0, 4'h0, 32'h14, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0));
    // out-of-range write aliases word 0, which must stay untouched
    tbl.push_back(mk(1, 0, 4'hF, 32'h0004_0000, 32'hCAFEF00D, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0));
    tbl.push_back(mk(1, 0, 4'h0, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0));
    tbl.push_back(mk(1, 0, 4'h0, 32'h20, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0));

    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(negedge clk);
      check($sformatf("row%0d_gnt0", i), {31'h0, m0_if.gnt}, {31'h0, tbl[i].g0});
      check($sformatf("row%0d_gnt1", i), {31'h0, m1_if.gnt}, {31'h0, tbl[i].g1});
      @(posedge clk); #1;
    end
    idle();
    repeat (4) @(posedge clk);
    #1;

    // reset while a read is in flight
    drive(mk(1, 0, 4'h0, 32'h14, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0));
    @(negedge clk);
    check("inflight_gnt0", {31'h0, m0_if.gnt}, 32'h1);
    @(posedge clk); #1;
    check("inflight_addrb", ram_addrb, 32'h14);
    rst = 1'b1;
    #1;
    check("arst_gnt0", {31'h0, m0_if.gnt}, 32'h0);
    check("arst_rvalid0", {31'h0, m0_if.rvalid}, 32'h0);
    check("arst_rdata0", m0_if.rdata, 32'h0);
    check("arst_err0", {31'h0, m0_if.err}, 32'h0);
    check("arst_web", {28'h0, ram_web}, 32'h0);
    check("arst_addrb", ram_addrb, 32'h0);
    check("arst_dinb", ram_dinb, 32'h0);
    idle();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_rvalid0_%0d", i), {31'h0, m0_if.rvalid}, 32'h0);
    end

    // after reset m0 wins the first contested cycle
    @(posedge clk); #1;
    drive(mk(1, 0, 4'h0, 32'h14, 32'h0, 1, 0, 4'h0, 32'h18, 32'h0, 1, 0));
    @(negedge clk);
    check("first_gnt0", {31'h0, m0_if.gnt}, 32'h1);
    check("first_gnt1", {31'h0, m1_if.gnt}, 32'h0);
    @(posedge clk); #1;
    m0_if.req = 1'b0;
    @(negedge clk);
    check("second_gnt1", {31'h0, m1_if.gnt}, 32'h1);
    @(posedge clk); #1;
    idle();
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("sb_drained", sbq.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
